arb_wrr_lock: RTL
=================

Name: arb_wrr_lock

Overview:
- Parametrised, registered weighted round-robin arbiter. Successor to the combinational fixed-priority arbiter.
- Arbitrates WIDTH packet requesters onto one shared downstream port.
- Grant is locked to the owner until its packet completes: downstream accepts a beat flagged last.
- Each requester may keep the port for a programmable number of consecutive packets (weight) before the round-robin pointer moves on.

Parameters:
- WIDTH, 4, number of requesters (>=2).
- WT_W, 4, width of each per-requester weight field.
- IDX_W, $clog2(WIDTH), width of grant_idx (derived, not overridden).
- TO_CYC, 255, lock timeout in cycles (used only with ARB_WRR_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- v_req  in  WIDTH  per-requester request.
- v_last  in  WIDTH  per-requester "current beat is last of packet".
- v_weight  in  WIDTH*WT_W  weight of requester i in bits [i*WT_W +: WT_W]; sampled when i wins a fresh turn.
- ack  in  1  downstream accepts current beat of owner.
- v_grant  out  WIDTH  one-hot registered grant, zero when idle.
- grant_vld  out  1  equals |v_grant.
- grant_idx  out  IDX_W  binary index of owner; holds last owner when idle.
- to_err  out  1  one-cycle pulse on forced release (tied 0 without macro).

Behaviour:
- Reset (async assert, sync release):
  - v_grant=0, grant_vld=0, grant_idx=0, to_err=0.
  - Pointer ptr=0, credit=0, state IDLE.
- State IDLE:
  - If |v_req: winner is the first set bit of v_req scanning from ptr upward, wrapping modulo WIDTH.
  - Next edge: v_grant=onehot(winner), grant_idx=winner, credit=v_weight[winner], state BUSY.
  - Latency: request to grant is 1 cycle.
  - If no requests, remain IDLE.
- State BUSY:
  - v_grant held constant regardless of v_req or v_last of any requester.
  - Requesters must not drop v_req mid-packet; this is not checked.
  - Done condition: ack && v_last[grant_idx]. ack without last, or last without ack, changes nothing.
  - On done, if credit!=0 && v_req[owner]: keep owner, credit<=credit-1, stay BUSY. No bubble.
  - On done otherwise: ptr<=(owner+1) mod WIDTH. Rearbitrate in the same cycle on current v_req, scanning from owner+1 with wrap; the owner is eligible last.
    - If a winner exists: grant it next edge with credit=v_weight[winner], stay BUSY. Back-to-back, no idle cycle.
    - If no winner: v_grant=0, state IDLE.
- Weight semantics: weight w lets a requester complete w+1 consecutive packets per turn. Weight 0 is plain round-robin.
- Single requester: keeps winning. ptr still advances on each turn end, and the sole requester is re-selected via wrap.
- ptr changes only on turn end. It is never updated in IDLE.
- Width rules:
  - Credit is WT_W bits and never underflows, because decrement occurs only when credit!=0.
  - The scan is a rotate/priority-encode over a doubled vector of 2*WIDTH bits.
- Mid-operation reset: all outputs return to reset values immediately (asynchronous). The in-flight packet is abandoned.
- No output ever has more than one bit set. grant_vld is never 1 with v_grant=0.

Optional Feature:
- Macro: ARB_WRR_TIMEOUT_EN.
- Defined:
  - A lock counter clears on each new grant and on each ack, and increments each BUSY cycle without ack.
  - When it reaches TO_CYC, the turn ends as if done with credit forced to 0: ptr advances and rearbitration happens the same cycle.
  - to_err pulses 1 for exactly one cycle.
- Undefined: no counter exists, to_err is constant 0, and a requester may hold the lock indefinitely.

Test Plan:
- WIDTH=4, weights=0, v_req=4'b1111, ack=1, v_last=4'b1111 every cycle -> grant sequence 0001,0010,0100,1000,0001; first grant 1 cycle after v_req; grant_vld=1 throughout.
- v_weight[0]=2, others 0, v_req=4'b0011, all single-beat packets with ack -> grants 0001,0001,0001,0010,0001,0001,0001,0010.
- Owner 2 granted, ack=1 with v_last=0 for 5 cycles, then requester 3 also requests -> v_grant stays 0100 until ack&&v_last[2], then 1000 on the next edge.
- Owner 1 completes with v_req=4'b0010 only -> v_grant stays 0010 (wrap re-selects); then v_req=0 at done -> v_grant=0, grant_vld=0, grant_idx stays 1.
- rst_n asserted low while BUSY with v_grant=0100 -> v_grant=0 and grant_idx=0 without a clock edge; after release with v_req=4'b0100 -> grant 0100 after 1 cycle (ptr restarted at 0).
- With ARB_WRR_TIMEOUT_EN, TO_CYC=8: owner 0 never gets ack, v_req=4'b0011 -> after 8 BUSY cycles to_err pulses once and v_grant becomes 0010. Without the macro -> 0001 is held indefinitely and to_err stays 0.

Source files
------------

// File: rtl/arb_wrr_lock.sv
// Registered weighted round-robin arbiter with per-packet grant lock.
// Optional lock timeout and forced release are enabled by defining ARB_WRR_TIMEOUT_EN.
module arb_wrr_lock #(
    parameter int WIDTH  = 4,
    parameter int WT_W   = 4,
    parameter int TO_CYC = 255,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        v_req,
    input  logic [WIDTH-1:0]        v_last,
    input  logic [WIDTH*WT_W-1:0]   v_weight,
    input  logic                    ack,
    output logic [WIDTH-1:0]        v_grant,
    output logic                    grant_vld,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    to_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [WT_W-1:0]     credit;

    logic [IDX_W-1:0]    next_ptr;
    logic [IDX_W-1:0]    scan_start;
    logic [2*WIDTH-1:0]  rot_full;
    logic [WIDTH-1:0]    rot;
    logic                win_found;
    logic [IDX_W-1:0]    win;
    logic [WIDTH-1:0]    win_onehot;
    logic [WT_W-1:0]     win_weight;
    logic                done;
    logic                keep;
    logic                timeout;
    logic                turn_end;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= WIDTH) s = s - WIDTH;
        return IDX_W'(s);
    endfunction

    // In BUSY the scan always starts just past the owner, so the owner is considered last.
    always_comb begin
        next_ptr   = wrap_add(grant_idx, 1);
        scan_start = (state == ST_BUSY) ? next_ptr : ptr;
        rot_full   = {v_req, v_req} >> scan_start;
        rot        = rot_full[WIDTH-1:0];
        win_found  = 1'b0;
        win        = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!win_found && rot[k]) begin
                win_found = 1'b1;
                win       = wrap_add(scan_start, k);
            end
        end
        win_onehot = WIDTH'(1) << win;
        win_weight = v_weight[int'(win)*WT_W +: WT_W];
    end

    assign done     = (state == ST_BUSY) && ack && v_last[grant_idx];
    assign keep     = done && (credit != '0) && v_req[grant_idx];
    assign turn_end = (done && !keep) || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            credit    <= '0;
            v_grant   <= '0;
            grant_idx <= '0;
        end else if (state == ST_IDLE) begin
            if (win_found) begin
                v_grant   <= win_onehot;
                grant_idx <= win;
                credit    <= win_weight;
                state     <= ST_BUSY;
            end
        end else if (keep) begin
            credit <= credit - WT_W'(1);
        end else if (turn_end) begin
            ptr <= next_ptr;
            if (win_found) begin
                v_grant   <= win_onehot;
                grant_idx <= win;
                credit    <= win_weight;
            end else begin
                v_grant <= '0;
                state   <= ST_IDLE;
            end
        end
    end

    assign grant_vld = |v_grant;

`ifdef ARB_WRR_TIMEOUT_EN
    localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

    logic [CNT_W-1:0] lock_cnt;
    logic             to_err_r;

    // Fires on the TO_CYC-th consecutive BUSY cycle without ack.
    assign timeout = (state == ST_BUSY) && !ack && (lock_cnt == CNT_W'(TO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            to_err_r <= 1'b0;
        end else begin
            to_err_r <= timeout;
            if (state != ST_BUSY || ack || turn_end) lock_cnt <= '0;
            else                                     lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    assign to_err = to_err_r;
`else
    logic [31:0] unused_to_cyc;
    assign unused_to_cyc = TO_CYC;
    assign timeout       = 1'b0;
    assign to_err        = 1'b0;
`endif

endmodule
